// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register: operation modes and
// command FSM states.
package shreg_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    CLR  = 3'd2,
    SHL  = 3'd3,
    SHR  = 3'd4,
    ASR  = 3'd5,
    ROL  = 3'd6,
    ROR  = 3'd7
  } mode_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_shift(input mode_t m);
    return m inside {SHL, SHR, ASR, ROL, ROR};
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the register: computes the next value and the
// bit pushed out, for every mode.
module shift_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_next,
  output logic             o_out_bit,
  output logic             o_out_valid
);

  always_comb begin
    o_next      = i_value;
    o_out_bit   = 1'b0;
    o_out_valid = 1'b0;
    case (i_mode)
      HOLD: o_next = i_value;
      LOAD: o_next = i_d;
      CLR:  o_next = '0;
      SHL: begin
        o_next      = {i_value[WIDTH-2:0], i_serial_in};
        o_out_bit   = i_value[WIDTH-1];
        o_out_valid = 1'b1;
      end
      SHR: begin
        o_next      = {i_serial_in, i_value[WIDTH-1:1]};
        o_out_bit   = i_value[0];
        o_out_valid = 1'b1;
      end
      ASR: begin
        o_next      = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
        o_out_bit   = i_value[0];
        o_out_valid = 1'b1;
      end
      ROL: begin
        o_next      = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
        o_out_bit   = i_value[WIDTH-1];
        o_out_valid = 1'b1;
      end
      ROR: begin
        o_next      = {i_value[0], i_value[WIDTH-1:1]};
        o_out_bit   = i_value[0];
        o_out_valid = 1'b1;
      end
      default: o_next = i_value;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and a multi-step shift/rotate
// command tracked by a two-state IDLE/RUN FSM.
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             serial_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] salida,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic             o_dbg_state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Command handshake: start is taken only on an enabled IDLE edge; busy is
  // high while steps remain; done pulses for exactly one cycle after the last
  // step, and a new start may be issued during that cycle.
  state_t           r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_salida;
  logic             r_serial_out;
  logic             r_busy;
  logic             r_done;

  mode_t            w_mode_in;
  mode_t            w_step_mode;
  logic [WIDTH-1:0] w_next;
  logic             w_out_bit;
  logic             w_out_valid;

  assign w_mode_in   = mode_t'(mode);
  assign w_step_mode = (r_state == RUN) ? r_mode : w_mode_in;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_mode      (w_step_mode),
    .i_value     (r_salida),
    .i_d         (D),
    .i_serial_in (serial_in),
    .o_next      (w_next),
    .o_out_bit   (w_out_bit),
    .o_out_valid (w_out_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mode       <= HOLD;
      r_cnt        <= '0;
      r_salida     <= '0;
      r_serial_out <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (enable) begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_mode <= w_mode_in;
              if (amount == '0) begin
                r_done <= 1'b1;
              end else begin
                r_salida <= w_next;
                if (w_out_valid) r_serial_out <= w_out_bit;
                // Step 1 happens here; RUN only covers the remaining steps.
                if (is_shift(w_mode_in) && (amount > ONE)) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_cnt   <= amount - ONE;
                end else begin
                  r_cnt  <= '0;
                  r_done <= 1'b1;
                end
              end
            end else begin
              r_salida <= w_next;
              if (w_out_valid) r_serial_out <= w_out_bit;
            end
          end
          RUN: begin
            r_salida <= w_next;
            if (w_out_valid) r_serial_out <= w_out_bit;
            r_cnt <= r_cnt - ONE;
            if (r_cnt == ONE) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign salida      = r_salida;
  assign serial_out  = r_serial_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = (r_state == RUN);

endmodule
